// File: rtl/halut_encoder_ctrl.sv
// Sequencer for the halut_encoder array: streams threshold words into the units, then drives encoder_i row by row.
// Optional stall counter output stall_cnt_o is enabled by defining HALUT_ENC_CTRL_PERF_EN.
module halut_encoder_ctrl #(
    parameter int unsigned K                  = 16,
    parameter int unsigned C                  = 32,
    parameter int unsigned DataTypeWidth      = 16,
    parameter int unsigned EncUnits           = 4,
    parameter int unsigned TreeDepth          = $clog2(K),
    parameter int unsigned CPerEncUnit        = C / EncUnits,
    parameter int unsigned ThreshMemAddrWidth = $clog2(CPerEncUnit * K),
    parameter int unsigned RowCycles          = CPerEncUnit * TreeDepth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef HALUT_ENC_CTRL_PERF_EN
    output logic [31:0]                   stall_cnt_o,
`endif
    input  logic                          cfg_valid_i,
    output logic                          cfg_ready_o,
    input  logic [$clog2(EncUnits)-1:0]   cfg_unit_i,
    input  logic [ThreshMemAddrWidth-1:0] cfg_addr_i,
    input  logic [DataTypeWidth-1:0]      cfg_data_i,
    output logic [EncUnits-1:0]           enc_we_o,
    output logic [ThreshMemAddrWidth-1:0] enc_waddr_o,
    output logic [DataTypeWidth-1:0]      enc_wdata_o,
    input  logic                          start_i,
    input  logic [15:0]                   num_rows_i,
    input  logic                          abort_i,
    input  logic                          row_valid_i,
    output logic                          row_ready_o,
    output logic                          encoder_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned CycWidth  = (RowCycles > 1) ? $clog2(RowCycles) : 1;
    localparam int unsigned UnitWidth = $clog2(EncUnits);
    localparam logic [CycWidth-1:0]  CycLast   = CycWidth'(RowCycles - 1);
    localparam logic [UnitWidth:0]   UnitLimit = (UnitWidth + 1)'(EncUnits);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        r_state, w_state_nxt;
    logic [CycWidth-1:0]           r_cyc_cnt, w_cyc_cnt_nxt;
    logic [15:0]                   r_row_cnt, w_row_cnt_nxt;
    logic [15:0]                   r_num_rows, w_num_rows_nxt;
    logic [EncUnits-1:0]           r_enc_we;
    logic [ThreshMemAddrWidth-1:0] r_enc_waddr;
    logic [DataTypeWidth-1:0]      r_enc_wdata;
    logic                          w_enc;
    logic                          w_row_ready;
    logic                          w_cfg_ready;
    logic                          w_start_acc;
    logic                          w_beat_acc;

    // State and counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cyc_cnt  <= '0;
            r_row_cnt  <= '0;
            r_num_rows <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc_cnt  <= w_cyc_cnt_nxt;
            r_row_cnt  <= w_row_cnt_nxt;
            r_num_rows <= w_num_rows_nxt;
        end
    end

    // Next-state and row sequencing
    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_cnt_nxt  = r_cyc_cnt;
        w_row_cnt_nxt  = r_row_cnt;
        w_num_rows_nxt = r_num_rows;
        w_enc          = 1'b0;
        w_row_ready    = 1'b0;
        w_cfg_ready    = 1'b0;
        w_start_acc    = 1'b0;
        case (r_state)
            IDLE: begin
                w_cfg_ready = !start_i;
                if (start_i) begin
                    w_start_acc    = 1'b1;
                    w_num_rows_nxt = num_rows_i;
                    w_cyc_cnt_nxt  = '0;
                    w_row_cnt_nxt  = '0;
                    w_state_nxt    = (num_rows_i != 16'd0) ? RUN : DONE;
                end
            end
            RUN: begin
                // row_valid_i only matters at a row boundary; mid-row drops are ignored
                w_enc = (r_cyc_cnt != '0) || row_valid_i;
                if (w_enc) begin
                    if (r_cyc_cnt == CycLast) begin
                        w_row_ready   = 1'b1;
                        w_cyc_cnt_nxt = '0;
                        w_row_cnt_nxt = r_row_cnt + 16'd1;
                        if (r_row_cnt == r_num_rows - 16'd1) begin
                            w_state_nxt = DRAIN;
                        end
                    end else begin
                        w_cyc_cnt_nxt = r_cyc_cnt + CycWidth'(1);
                    end
                end
                if (abort_i) begin
                    w_state_nxt   = IDLE;
                    w_cyc_cnt_nxt = '0;
                    w_row_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                w_state_nxt = abort_i ? IDLE : DONE;
                if (abort_i) begin
                    w_cyc_cnt_nxt = '0;
                    w_row_cnt_nxt = '0;
                end
            end
            DONE: begin
                w_state_nxt   = IDLE;
                w_cyc_cnt_nxt = '0;
                w_row_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_beat_acc = w_cfg_ready && cfg_valid_i && ({1'b0, cfg_unit_i} < UnitLimit);

    // Threshold write beat is registered and issued one cycle after acceptance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enc_we    <= '0;
            r_enc_waddr <= '0;
            r_enc_wdata <= '0;
        end else begin
            r_enc_we <= w_beat_acc ? (EncUnits'(1) << cfg_unit_i) : '0;
            if (w_beat_acc) begin
                r_enc_waddr <= cfg_addr_i;
                r_enc_wdata <= cfg_data_i;
            end
        end
    end

`ifdef HALUT_ENC_CTRL_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == RUN) && !w_enc && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`endif

    assign cfg_ready_o = w_cfg_ready;
    assign enc_we_o    = r_enc_we;
    assign enc_waddr_o = r_enc_waddr;
    assign enc_wdata_o = r_enc_wdata;
    assign encoder_o   = w_enc;
    assign row_ready_o = w_row_ready;
    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);

endmodule

// File: tb/tb_halut_encoder_ctrl.sv
// Testbench for halut_encoder_ctrl: cfg-beat vector table, hand-written job sequences and a randomized run
// against a cycle-count reference model.
module tb_halut_encoder_ctrl;

    localparam int unsigned RC = 32;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        cfg_valid_i, cfg_ready_o;
    logic [1:0]  cfg_unit_i;
    logic [6:0]  cfg_addr_i, enc_waddr_o;
    logic [15:0] cfg_data_i, enc_wdata_o, num_rows_i;
    logic [3:0]  enc_we_o;
    logic        start_i, abort_i, row_valid_i, row_ready_o, encoder_o, busy_o, done_o;
`ifdef HALUT_ENC_CTRL_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: job progress measured in active encoder cycles
    int          m_mode, m_active, m_n;
    longint      m_stall;
    logic        m_enc, m_rr;
    logic [3:0]  m_we;
    logic [6:0]  m_waddr;
    logic [15:0] m_wdata;

    logic s_enc, s_rr, s_done, s_busy, s_rdy;
    int   h_enc_cnt, h_done_at, h_first_idle;
    int   h_rr[$];
    logic h_enc_bits[150];

    typedef struct {
        logic        v;
        logic [1:0]  u;
        logic [6:0]  a;
        logic [15:0] d;
        logic        rdy;
        logic [3:0]  we;
        logic [6:0]  wa;
        logic [15:0] wd;
    } vec_t;
    vec_t vt[6];

    always #5 clk_i = ~clk_i;

    halut_encoder_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
`ifdef HALUT_ENC_CTRL_PERF_EN
        .stall_cnt_o (stall_cnt_o),
`endif
        .cfg_valid_i (cfg_valid_i),
        .cfg_ready_o (cfg_ready_o),
        .cfg_unit_i  (cfg_unit_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_data_i  (cfg_data_i),
        .enc_we_o    (enc_we_o),
        .enc_waddr_o (enc_waddr_o),
        .enc_wdata_o (enc_wdata_o),
        .start_i     (start_i),
        .num_rows_i  (num_rows_i),
        .abort_i     (abort_i),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .encoder_o   (encoder_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_active = 0; m_n = 0; m_stall = 0;
        m_we = '0; m_waddr = '0; m_wdata = '0;
    endtask

    task automatic model_cmp();
        m_enc = 1'b0;
        m_rr  = 1'b0;
        if (m_mode == M_RUN) begin
            m_enc = ((m_active % RC) != 0) || row_valid_i;
            m_rr  = m_enc && ((m_active % RC) == RC - 1);
        end
        chk("encoder",   32'(encoder_o),   32'(m_enc));
        chk("row_ready", 32'(row_ready_o), 32'(m_rr));
        chk("busy",      32'(busy_o),      32'(m_mode != M_IDLE));
        chk("done",      32'(done_o),      32'(m_mode == M_DONE));
        chk("cfg_ready", 32'(cfg_ready_o), 32'((m_mode == M_IDLE) && !start_i));
        chk("enc_we",    32'(enc_we_o),    32'(m_we));
        chk("enc_waddr", 32'(enc_waddr_o), 32'(m_waddr));
        chk("enc_wdata", 32'(enc_wdata_o), 32'(m_wdata));
`ifdef HALUT_ENC_CTRL_PERF_EN
        chk("stall_cnt", stall_cnt_o, 32'(m_stall));
`endif
        s_enc = encoder_o; s_rr = row_ready_o; s_done = done_o; s_busy = busy_o; s_rdy = cfg_ready_o;
    endtask

    task automatic model_adv();
        if (m_mode == M_IDLE && cfg_valid_i && !start_i) begin
            m_we = 4'(1) << cfg_unit_i; m_waddr = cfg_addr_i; m_wdata = cfg_data_i;
        end else begin
            m_we = '0;
        end
        case (m_mode)
            M_IDLE: if (start_i) begin
                m_n = int'(num_rows_i); m_active = 0; m_stall = 0;
                m_mode = (m_n == 0) ? M_DONE : M_RUN;
            end
            M_RUN: begin
                if (!m_enc && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
                if (abort_i) m_mode = M_IDLE;
                else if (m_enc) begin
                    m_active++;
                    if (m_active == m_n * int'(RC)) m_mode = M_DRAIN;
                end
            end
            M_DRAIN: m_mode = abort_i ? M_IDLE : M_DONE;
            default: m_mode = M_IDLE;
        endcase
    endtask

    // Inputs are set 1 time unit after the rising edge; outputs are checked 2 units later
    task automatic cyc();
        #2;
        model_cmp();
        model_adv();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_job(input int n, input int st_at, input int st_len, input int ab_at);
        h_enc_cnt = 0; h_done_at = -1; h_first_idle = -1; h_rr.delete();
        cfg_valid_i = 1'b0; abort_i = 1'b0;
        start_i = 1'b1; num_rows_i = 16'(n); row_valid_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 150; i++) begin
            row_valid_i = !(i >= st_at && i < st_at + st_len);
            abort_i     = (i == ab_at);
            cyc();
            h_enc_bits[i] = s_enc;
            if (s_enc) h_enc_cnt++;
            if (s_rr) h_rr.push_back(i);
            if (s_done && h_done_at < 0) h_done_at = i;
            if (!s_busy && h_first_idle < 0) h_first_idle = i;
        end
        abort_i = 1'b0;
    endtask

    function automatic logic [31:0] rr_at(input int k);
        return (h_rr.size() > k) ? 32'(h_rr[k]) : 32'hFFFF_FFFF;
    endfunction

    initial begin
        rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_unit_i = '0; cfg_addr_i = '0; cfg_data_i = '0;
        start_i = 1'b0; num_rows_i = '0; abort_i = 1'b0; row_valid_i = 1'b0;
        model_reset();
        vt[0] = '{1'b1, 2'd2, 7'h05, 16'h3C00, 1'b1, 4'b0100, 7'h05, 16'h3C00};
        vt[1] = '{1'b0, 2'd3, 7'h7F, 16'hFFFF, 1'b1, 4'b0000, 7'h05, 16'h3C00};
        vt[2] = '{1'b1, 2'd0, 7'h7F, 16'hFFFF, 1'b1, 4'b0001, 7'h7F, 16'hFFFF};
        vt[3] = '{1'b1, 2'd3, 7'h00, 16'h0001, 1'b1, 4'b1000, 7'h00, 16'h0001};
        vt[4] = '{1'b1, 2'd1, 7'h2A, 16'hA5A5, 1'b1, 4'b0010, 7'h2A, 16'hA5A5};
        vt[5] = '{1'b0, 2'd0, 7'h00, 16'h0000, 1'b1, 4'b0000, 7'h2A, 16'hA5A5};

        repeat (2) @(posedge clk_i);
        #3;
        chk("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        chk("rst_enc_we",    32'(enc_we_o),    32'd0);
        chk("rst_waddr",     32'(enc_waddr_o), 32'd0);
        chk("rst_wdata",     32'(enc_wdata_o), 32'd0);
        chk("rst_encoder",   32'(encoder_o),   32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_done",      32'(done_o),      32'd0);
        chk("rst_row_ready", 32'(row_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Threshold write beats: each record's outputs appear the cycle after it is applied
        for (int i = 0; i < 6; i++) begin
            cfg_valid_i = vt[i].v; cfg_unit_i = vt[i].u; cfg_addr_i = vt[i].a; cfg_data_i = vt[i].d;
            #2;
            chk("tbl_ready", 32'(cfg_ready_o), 32'(vt[i].rdy));
            @(posedge clk_i);
            #1;
            chk("tbl_we",    32'(enc_we_o),    32'(vt[i].we));
            chk("tbl_waddr", 32'(enc_waddr_o), 32'(vt[i].wa));
            chk("tbl_wdata", 32'(enc_wdata_o), 32'(vt[i].wd));
        end
        cfg_valid_i = 1'b0;
        m_we = vt[5].we; m_waddr = vt[5].wa; m_wdata = vt[5].wd;

        // Three rows back to back
        run_job(3, -1, 0, -1);
        chk("t2_enc_cnt", 32'(h_enc_cnt), 32'd96);
        chk("t2_rr_n",    32'(h_rr.size()), 32'd3);
        chk("t2_rr0",     rr_at(0), 32'd31);
        chk("t2_rr1",     rr_at(1), 32'd63);
        chk("t2_rr2",     rr_at(2), 32'd95);
        chk("t2_done_at", 32'(h_done_at), 32'd97);
        chk("t2_enc_first", 32'(h_enc_bits[0]),  32'd1);
        chk("t2_enc_after", 32'(h_enc_bits[96]), 32'd0);

        // Five-cycle stall at the start of the second row
        run_job(2, 32, 5, -1);
        chk("t3_enc_cnt", 32'(h_enc_cnt), 32'd64);
        for (int i = 32; i < 37; i++) chk("t3_stall_gap", 32'(h_enc_bits[i]), 32'd0);
        chk("t3_enc_before", 32'(h_enc_bits[31]), 32'd1);
        chk("t3_enc_resume", 32'(h_enc_bits[37]), 32'd1);
        chk("t3_rr0",     rr_at(0), 32'd31);
        chk("t3_rr1",     rr_at(1), 32'd68);
        chk("t3_done_at", 32'(h_done_at), 32'd70);
`ifdef HALUT_ENC_CTRL_PERF_EN
        chk("t3_stall_cnt", stall_cnt_o, 32'd5);
`endif

        // Abort in row 0, then a normal one-row job
        run_job(2, -1, 0, 10);
        chk("t4_enc_at_abort", 32'(h_enc_bits[10]), 32'd1);
        chk("t4_enc_after",    32'(h_enc_bits[11]), 32'd0);
        chk("t4_idle_at",      32'(h_first_idle), 32'd11);
        chk("t4_no_done",      32'(h_done_at), 32'hFFFF_FFFF);
        run_job(1, -1, 0, -1);
        chk("t4_rerun_enc",  32'(h_enc_cnt), 32'd32);
        chk("t4_rerun_done", 32'(h_done_at), 32'd33);

        // Zero-row job; start wins over a simultaneous cfg beat
        cfg_valid_i = 1'b1; cfg_unit_i = 2'd1; cfg_addr_i = 7'h03; cfg_data_i = 16'h1234;
        start_i = 1'b1; num_rows_i = 16'd0; row_valid_i = 1'b1;
        cyc();
        chk("t5_ready_on_start", 32'(s_rdy), 32'd0);
        cfg_valid_i = 1'b0; start_i = 1'b0;
        cyc();
        chk("t5_done", 32'(s_done), 32'd1);
        chk("t5_enc",  32'(s_enc),  32'd0);
        chk("t5_we",   32'(enc_we_o), 32'd0);
        cyc();
        chk("t5_idle", 32'(s_busy), 32'd0);

        // Asynchronous reset in the middle of a job
        start_i = 1'b1; num_rows_i = 16'd3; row_valid_i = 1'b1;
        cyc();
        start_i = 1'b0;
        for (int i = 0; i < 40; i++) cyc();
        #2;
        rst_i = 1'b1;
        #1;
        chk("t6_encoder",  32'(encoder_o),   32'd0);
        chk("t6_busy",     32'(busy_o),      32'd0);
        chk("t6_row_ready",32'(row_ready_o), 32'd0);
        chk("t6_done",     32'(done_o),      32'd0);
        chk("t6_cfg_ready",32'(cfg_ready_o), 32'd1);
        chk("t6_enc_we",   32'(enc_we_o),    32'd0);
        chk("t6_waddr",    32'(enc_waddr_o), 32'd0);
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #2;
        chk("t6_ready_after", 32'(cfg_ready_o), 32'd1);
        @(posedge clk_i);
        #1;

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cfg_valid_i = 1'($urandom_range(0, 1));
            cfg_unit_i  = 2'($urandom);
            cfg_addr_i  = 7'($urandom);
            cfg_data_i  = 16'($urandom);
            start_i     = ($urandom_range(0, 15) == 0);
            num_rows_i  = 16'($urandom_range(0, 3));
            abort_i     = ($urandom_range(0, 99) == 0);
            row_valid_i = ($urandom_range(0, 4) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
